// File: rtl/uart_mmio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_mmio_ctrl_pkg
// Brief  : Shared constants for the UART MMIO controller: address window
//          nibble, register offsets and access-FSM state encodings.
// Rev    : 1.0  initial release
// ============================================================================
package uart_mmio_ctrl_pkg;

    // cpu_addr[31:28] value selecting the UART window
    localparam logic [3:0] c_uart_base  = 4'h8;

    // Register offsets (cpu_addr[7:0])
    localparam logic [7:0] c_off_txstat = 8'h00;
    localparam logic [7:0] c_off_rxstat = 8'h04;
    localparam logic [7:0] c_off_txdata = 8'h08;
    localparam logic [7:0] c_off_rxdata = 8'h0C;
    localparam logic [7:0] c_off_cycles = 8'h10;
    localparam logic [7:0] c_off_stalls = 8'h14;

    // Access FSM state encodings
    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_wait    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with first-word-fall-through output. Full/empty
//          come from read/write pointers carrying one extra wrap bit.
//          A push while full and a pop while empty are ignored.
// Ports  : clk, rst_n        clock, async active-low reset
//          push, din         write strobe and data
//          pop, dout         read strobe and head-of-queue data
//          full, empty       occupancy flags
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int           c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0] c_ptr_one = {{c_aw{1'b0}}, 1'b1};

    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    // Same index with opposite wrap bits means the writer is a full lap ahead
    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                    (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);

    // Flags are pre-edge, so a full FIFO refuses a push even when popped
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_aw-1:0]] <= din;
    end

    assign dout = r_mem[r_rptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_mmio_ctrl
// Brief  : CPU data-port controller for the UART window (addr[31:28]==8).
//          Decodes the register map, buffers TX/RX bytes in FIFOs, stalls the
//          pipeline while a TXDATA write or RXDATA read cannot complete, and
//          keeps free-running cycle and stall counters.
// Ports  : clk, rst_n                       clock, async active-low reset
//          cpu_addr/re/we/wdata             CPU load/store request
//          cpu_rdata                        registered load data
//          cpu_stall                        pipeline freeze
//          uart_din/_valid/_ready           byte stream to transmitter
//          uart_dout/_valid/_ready          byte stream from receiver
// Rev    : 1.0  initial release
// ============================================================================
module uart_mmio_ctrl
    import uart_mmio_ctrl_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_sel;
    logic [7:0] w_off;
    logic       w_wr;
    logic       w_rd;
    logic       w_wr_tx;
    logic       w_rd_rx;
    logic       w_block;

    logic       w_tx_full;
    logic       w_tx_empty;
    logic [7:0] w_tx_head;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_head;

    assign w_sel   = (cpu_addr[31:28] == c_uart_base);
    assign w_off   = cpu_addr[7:0];
    // A store takes priority over a load issued in the same cycle
    assign w_wr    = w_sel & cpu_we;
    assign w_rd    = w_sel & cpu_re & ~cpu_we;
    assign w_wr_tx = w_wr & (w_off == c_off_txdata);
    assign w_rd_rx = w_rd & (w_off == c_off_rxdata);
    assign w_block = (w_wr_tx & w_tx_full) | (w_rd_rx & w_rx_empty);

    // Address bits outside the decoded fields and the upper store bytes
    logic w_unused;
    assign w_unused = ^{cpu_addr[27:8], cpu_wdata[31:8]};

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       r_op_wr;      // 1: parked TXDATA write, 0: parked RXDATA read
    logic [7:0] r_wbyte;
    logic       w_done;

    assign w_done = r_op_wr ? ~w_tx_full : ~w_rx_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_block) w_state_nxt = c_st_wait;
            c_st_wait: if (w_done)  w_state_nxt = c_st_idle;
            default:                w_state_nxt = c_st_idle;
        endcase
    end

    logic        w_stall_raw;
    logic        w_latch;
    logic        w_tx_push;
    logic [7:0]  w_tx_data;
    logic        w_rx_pop;
    logic        w_rd_load;
    logic [31:0] w_rd_value;
    logic        w_clr_cycles;
    logic        w_clr_stalls;
    logic [31:0] r_cycles;
    logic [31:0] r_stalls;

    always_comb begin
        w_stall_raw  = 1'b0;
        w_latch      = 1'b0;
        w_tx_push    = 1'b0;
        w_tx_data    = cpu_wdata[7:0];
        w_rx_pop     = 1'b0;
        w_rd_load    = 1'b0;
        w_rd_value   = 32'h0;
        w_clr_cycles = 1'b0;
        w_clr_stalls = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_stall_raw  = w_block;
                w_latch      = w_block;
                w_tx_push    = w_wr_tx & ~w_tx_full;
                w_rx_pop     = w_rd_rx & ~w_rx_empty;
                w_rd_load    = w_rd & ~w_block;
                w_clr_cycles = w_wr & (w_off == c_off_cycles);
                w_clr_stalls = w_wr & (w_off == c_off_stalls);
                case (w_off)
                    c_off_txstat: w_rd_value = {31'h0, ~w_tx_full};
                    c_off_rxstat: w_rd_value = {31'h0, ~w_rx_empty};
                    c_off_rxdata: w_rd_value = {24'h0, w_rx_head};
                    c_off_cycles: w_rd_value = r_cycles;
                    c_off_stalls: w_rd_value = r_stalls;
                    default:      w_rd_value = 32'h0;
                endcase
            end
            c_st_wait: begin
                // CPU inputs are frozen out; only the parked op can finish
                w_stall_raw = ~w_done;
                w_tx_push   = r_op_wr & w_done;
                w_tx_data   = r_wbyte;
                w_rx_pop    = ~r_op_wr & w_done;
                w_rd_load   = ~r_op_wr & w_done;
                w_rd_value  = {24'h0, w_rx_head};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_wr <= 1'b0;
            r_wbyte <= 8'h0;
        end else if (w_latch) begin
            r_op_wr <= w_wr_tx;
            r_wbyte <= cpu_wdata[7:0];
        end
    end

    // Gating with rst_n drops stall the instant reset asserts, even mid-WAIT
    assign cpu_stall = w_stall_raw & rst_n;

    // ------------------------------------------------------------------
    // Read data and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= 32'h0;
            r_cycles  <= 32'h0;
            r_stalls  <= 32'h0;
        end else begin
            if (w_rd_load) cpu_rdata <= w_rd_value;

            if (w_clr_cycles) r_cycles <= 32'h0;
            else              r_cycles <= r_cycles + 32'd1;

            if (w_clr_stalls)
                r_stalls <= 32'h0;
            else if (cpu_stall && (r_stalls != 32'hFFFF_FFFF))
                r_stalls <= r_stalls + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic w_tx_pop;
    logic w_rx_push;

    assign uart_din_valid  = ~w_tx_empty;
    assign uart_din        = w_tx_empty ? 8'h0 : w_tx_head;
    assign w_tx_pop        = uart_din_valid & uart_din_ready;
    assign uart_dout_ready = ~w_rx_full & rst_n;
    assign w_rx_push       = uart_dout_valid & uart_dout_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_tx_push),
        .din   (w_tx_data),
        .pop   (w_tx_pop),
        .dout  (w_tx_head),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rx_push),
        .din   (uart_dout),
        .pop   (w_rx_pop),
        .dout  (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

endmodule
`default_nettype wire
